// File: rtl/draw_pkg.sv
// Shared definitions for the drawing path: blitter FSM states, screen geometry
// and colour width.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 9;

  // Counter width for a range of n values; never below one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_scan_counter.sv
// Row-major raster counter: column, row and a running linear address that
// advances by one per step, so no multiplier is needed for addressing.
module raster_scan_counter
  import draw_pkg::*;
#(
  parameter int W      = 80,
  parameter int H      = 40,
  parameter int ADDR_W = 12,
  parameter int CX_W   = width_of(W),
  parameter int CY_W   = width_of(H)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  output logic [CX_W-1:0]   cx,
  output logic [CY_W-1:0]   cy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(H - 1);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cx   <= '0;
      cy   <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (cx == CX_LAST) begin
        cx <= '0;
        cy <= cy + CY_W'(1);
      end else begin
        cx <= cx + CX_W'(1);
      end
    end
  end

  assign last = (cx == CX_LAST) && (cy == CY_LAST);

endmodule

// File: rtl/sprite_blitter.sv
// Streams a SPR_W x SPR_H sprite from a synchronous ROM to the VGA plot port,
// one pixel per clock, clipping off-screen pixels. Define
// SPRITE_BLITTER_TRANSPARENCY_EN to suppress plots of the TRANSPARENT key colour.
module sprite_blitter
  import draw_pkg::*;
#(
  parameter int                  SPR_W       = 80,
  parameter int                  SPR_H       = 40,
  parameter int                  ADDR_W      = 12,
  parameter int                  COLOR_W     = draw_pkg::COLOR_W,
  parameter int                  X_W         = 8,
  parameter int                  Y_W         = 7,
  parameter int                  SCREEN_W    = draw_pkg::SCREEN_W,
  parameter int                  SCREEN_H    = draw_pkg::SCREEN_H,
  parameter logic [COLOR_W-1:0]  TRANSPARENT = 9'h1FF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] colour,
  output state_t             fsm_state
);

  localparam int CX_W = width_of(SPR_W);
  localparam int CY_W = width_of(SPR_H);
  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  state_t          state, state_next;
  logic            drain_cnt, drain_next;
  logic            clear, advance;
  logic [X_W-1:0]  x0_lat;
  logic [Y_W-1:0]  y0_lat;
  logic [CX_W-1:0] cx, s1_cx;
  logic [CY_W-1:0] cy, s1_cy;
  logic            last;
  logic            s1_valid;
  logic [XS_W-1:0] xs;
  logic [YS_W-1:0] ys;
  logic            in_bounds, key_hit;

  raster_scan_counter #(
    .W      (SPR_W),
    .H      (SPR_H),
    .ADDR_W (ADDR_W),
    .CX_W   (CX_W),
    .CY_W   (CY_W)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .advance (advance),
    .cx      (cx),
    .cy      (cy),
    .addr    (rom_addr),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      x0_lat    <= '0;
      y0_lat    <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      if (clear) begin
        x0_lat <= x0;
        y0_lat <= y0;
      end
    end
  end

  // DRAIN lasts two cycles; done marks the second, when the last pixel emerges.
  always_comb begin
    state_next = state;
    drain_next = 1'b0;
    clear      = 1'b0;
    advance    = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (last) state_next = DRAIN;
      end
      DRAIN: begin
        drain_next = ~drain_cnt;
        if (drain_cnt) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;

  // Stage 1: pixel coordinates travel alongside the ROM read.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_cx    <= '0;
      s1_cy    <= '0;
    end else begin
      s1_valid <= (state == RUN);
      s1_cx    <= cx;
      s1_cy    <= cy;
    end
  end

  // One extra bit on each sum so wrap-around past the coordinate width clips.
  assign xs        = XS_W'(x0_lat) + XS_W'(s1_cx);
  assign ys        = YS_W'(y0_lat) + YS_W'(s1_cy);
  assign in_bounds = (xs < XS_W'(SCREEN_W)) && (ys < YS_W'(SCREEN_H));
  assign key_hit   = KEY_EN && (rom_q == TRANSPARENT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= s1_valid && in_bounds && !key_hit;
      if (s1_valid) begin
        x      <= xs[X_W-1:0];
        y      <= ys[Y_W-1:0];
        colour <= rom_q;
      end
    end
  end

endmodule
